axi_llc_multi_chan_splitter: RTL
================================

AXI_LLC_MULTI_CHAN_SPLITTER -- requirements
Module: axi_llc_multi_chan_splitter

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of AX slave channels arbitrated (1..8).
REQ-002 SHALL have parameter AddrWidth, default 64: AX and descriptor address width.
REQ-003 SHALL have parameter IdWidth, default 4: AX ID width.
REQ-004 SHALL have parameter LineBytes, default 64: cache line size, power of two.
REQ-005 SHALL have parameter BeatBytes, default 8: data beat size, power of two, not larger than LineBytes.
REQ-006 SHALL have ports `clk_i` (in, 1, clock, rising edge) and `rst_ni` (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports `ax_addr_i` (in, NumPorts*AddrWidth), `ax_id_i` (in, NumPorts*IdWidth) and `ax_len_i` (in, NumPorts*8): per-port INCR burst, with port p at slice p.
REQ-008 SHALL have ports `ax_valid_i` (in, NumPorts) and `ax_ready_o` (out, NumPorts): per-port handshake.
REQ-009 SHALL have ports `desc_addr_o` (out, AddrWidth), `desc_id_o` (out, IdWidth), `desc_port_o` (out, $clog2(NumPorts) with a minimum of 1), `desc_len_o` (out, 8, beats-1) and `desc_last_o` (out, 1).
REQ-010 SHALL have ports `desc_valid_o` (out, 1) and `desc_ready_i` (in, 1): descriptor handshake.
REQ-011 SHALL have ports `flush_i` (in, 1, blocks new bursts) and `unit_busy_o` (out, 1, a burst is being split).

Function
REQ-012 SHALL split each accepted burst into one descriptor per touched cache line, in ascending address order.
REQ-013 SHALL compute the first descriptor's beats as min(len+1, (LineBytes - addr mod LineBytes)/BeatBytes), with addr taken beat-aligned, and set desc_addr_o to the unmodified burst address.
REQ-014 SHALL give each following descriptor the next line-aligned address and beats = min(remaining, LineBytes/BeatBytes).
REQ-015 SHALL assert desc_last_o only on the descriptor that covers the final beat of the burst.
REQ-016 SHALL use two states, IDLE and BUSY.
REQ-017 In IDLE with flush_i low, SHALL pick the first valid port at or after the round-robin pointer, assert only that port's ax_ready_o, and drive its first descriptor combinationally in the same cycle (zero latency).
REQ-018 In IDLE, SHALL go to BUSY after a winning AX handshake unless the descriptor handshakes in the same cycle with desc_last_o set.
REQ-019 In IDLE, SHALL store the remainder of the burst in the register on descriptor handshake, or the whole burst if desc_ready_i is low.
REQ-020 In BUSY, SHALL drive desc_valid_o high from the registered burst, keep all ax_ready_o low, and hold every descriptor output stable while desc_ready_i is low.
REQ-021 In BUSY, SHALL advance the register on each descriptor handshake and return to IDLE after the handshake of the last descriptor; a new burst is accepted no earlier than the following cycle.
REQ-022 SHALL set the round-robin pointer to (winner+1) mod NumPorts on each AX handshake.
REQ-023 SHALL keep all ax_ready_o low in IDLE while flush_i is high; flush_i SHALL NOT affect a burst already in BUSY.
REQ-024 SHALL assert unit_busy_o in BUSY, and in IDLE whenever an AX handshake occurs.
REQ-025 SHALL perform all address arithmetic modulo 2^AddrWidth, so a line crossing at the top of the address space wraps to 0.

Reset
REQ-026 SHALL, on rst_ni low, immediately enter IDLE, clear the round-robin pointer to 0, clear the burst register, and drive desc_valid_o, unit_busy_o and every ax_ready_o bit to 0.
REQ-027 SHALL discard without output any burst that was mid-split when reset is asserted.

Configuration
REQ-028 SHALL, with macro AXI_LLC_SPLIT_PERF_EN defined, provide output `perf_desc_cnt_o` (32 bits) that increments on each descriptor handshake, wraps at 2^32, and resets to 0.
REQ-029 SHALL, without AXI_LLC_SPLIT_PERF_EN, omit the `perf_desc_cnt_o` port and the counter logic entirely.

Verification (defaults, 8 beats/line)
REQ-030 Port0 addr 0x38, len 3, desc_ready_i=1 -> desc {0x38, len 0, last 0} in the same cycle, then {0x40, len 2, last 1}, then IDLE.
REQ-031 Port0 addr 0x0, len 15 -> two descriptors, {0x0, len 7, last 0} and {0x40, len 7, last 1}.
REQ-032 Both ports valid every cycle from reset -> grants in order 0,1,0,1 and desc_port_o matches each grant.
REQ-033 desc_ready_i=0 for 5 cycles with a burst pending -> desc outputs stable and ax_ready_o=0 throughout, with no lost beats.
REQ-034 flush_i=1 in IDLE with port1 valid -> ax_ready_o=0; release flush -> port1 granted the next cycle.
REQ-035 rst_ni pulsed low during BUSY -> desc_valid_o=0 immediately, and the next burst starts from port 0 priority.

Source files
------------

// File: rtl/axi_llc_multi_chan_splitter.sv
// rtl/axi_llc_multi_chan_splitter.sv - round-robin AX arbiter that splits INCR bursts into per-cache-line descriptors
// Optional: define AXI_LLC_SPLIT_PERF_EN to add the perf_desc_cnt_o descriptor counter.
module axi_llc_multi_chan_splitter #(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 4,
    parameter int LineBytes = 64,
    parameter int BeatBytes = 8,
    localparam int PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumPorts*AddrWidth-1:0] ax_addr_i,
    input  logic [NumPorts*IdWidth-1:0]   ax_id_i,
    input  logic [NumPorts*8-1:0]         ax_len_i,
    input  logic [NumPorts-1:0]           ax_valid_i,
    output logic [NumPorts-1:0]           ax_ready_o,
    output logic [AddrWidth-1:0]          desc_addr_o,
    output logic [IdWidth-1:0]            desc_id_o,
    output logic [PortW-1:0]              desc_port_o,
    output logic [7:0]                    desc_len_o,
    output logic                          desc_last_o,
    output logic                          desc_valid_o,
    input  logic                          desc_ready_i,
    input  logic                          flush_i,
    output logic                          unit_busy_o
`ifdef AXI_LLC_SPLIT_PERF_EN
    ,
    output logic [31:0]                   perf_desc_cnt_o
`endif
);

    localparam int BeatsPerLine = LineBytes / BeatBytes;
    localparam int BeatShift    = $clog2(BeatBytes);
    localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineBytes - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               r_state;
    logic [PortW-1:0]     r_rr_ptr;
    logic [PortW-1:0]     r_port;
    logic [AddrWidth-1:0] r_addr;
    logic [IdWidth-1:0]   r_id;
    logic [15:0]          r_rem;

    logic                 w_grant_valid;
    logic [PortW-1:0]     w_winner;
    logic [AddrWidth-1:0] w_cur_addr;
    logic [AddrWidth-1:0] w_next_addr;
    logic [IdWidth-1:0]   w_cur_id;
    logic [PortW-1:0]     w_cur_port;
    logic [15:0]          w_cur_rem;
    logic [15:0]          w_room;
    logic [15:0]          w_beats;
    logic                 w_last;
    logic                 w_desc_hs;

    // First valid port at or after the round-robin pointer; gated by reset so ready is low during reset
    always_comb begin
        w_grant_valid = 1'b0;
        w_winner      = '0;
        if (rst_ni && r_state == IDLE && !flush_i) begin
            for (int i = 0; i < NumPorts; i++) begin
                if (!w_grant_valid && ax_valid_i[(int'(r_rr_ptr) + i) % NumPorts]) begin
                    w_grant_valid = 1'b1;
                    w_winner      = PortW'((int'(r_rr_ptr) + i) % NumPorts);
                end
            end
        end
    end

    // Descriptor source: the winning port in IDLE (zero latency), the burst register in BUSY
    always_comb begin
        if (r_state == BUSY) begin
            w_cur_addr = r_addr;
            w_cur_id   = r_id;
            w_cur_port = r_port;
            w_cur_rem  = r_rem;
        end else begin
            w_cur_addr = ax_addr_i[w_winner*AddrWidth +: AddrWidth];
            w_cur_id   = ax_id_i[w_winner*IdWidth +: IdWidth];
            w_cur_port = w_winner;
            w_cur_rem  = 16'(ax_len_i[w_winner*8 +: 8]) + 16'd1;
        end
        w_room      = 16'(BeatsPerLine) - 16'((w_cur_addr & LineMask) >> BeatShift);
        w_beats     = (w_cur_rem < w_room) ? w_cur_rem : w_room;
        w_last      = (w_cur_rem <= w_room);
        w_next_addr = (w_cur_addr & ~LineMask) + AddrWidth'(LineBytes);
    end

    always_comb begin
        ax_ready_o = '0;
        if (w_grant_valid) begin
            ax_ready_o[w_winner] = 1'b1;
        end
    end

    assign desc_valid_o = (r_state == BUSY) || w_grant_valid;
    assign desc_addr_o  = w_cur_addr;
    assign desc_id_o    = w_cur_id;
    assign desc_port_o  = w_cur_port;
    assign desc_len_o   = 8'(w_beats - 16'd1);
    assign desc_last_o  = w_last;
    assign unit_busy_o  = (r_state == BUSY) || w_grant_valid;
    assign w_desc_hs    = desc_valid_o && desc_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_port   <= '0;
            r_addr   <= '0;
            r_id     <= '0;
            r_rem    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_rr_ptr <= (w_winner == PortW'(NumPorts - 1)) ? '0 : w_winner + 1'b1;
                        r_id     <= w_cur_id;
                        r_port   <= w_cur_port;
                        if (!desc_ready_i) begin
                            r_addr  <= w_cur_addr;
                            r_rem   <= w_cur_rem;
                            r_state <= BUSY;
                        end else if (!w_last) begin
                            r_addr  <= w_next_addr;
                            r_rem   <= w_cur_rem - w_beats;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (desc_ready_i) begin
                        if (w_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr <= w_next_addr;
                            r_rem  <= w_cur_rem - w_beats;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AXI_LLC_SPLIT_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_desc_cnt_o <= '0;
        end else if (w_desc_hs) begin
            perf_desc_cnt_o <= perf_desc_cnt_o + 32'd1;
        end
    end
`else
    logic w_unused_hs;
    assign w_unused_hs = w_desc_hs;
`endif

endmodule
